// File: rtl/execute_mem_storebuffer_checkpoints_mc.sv
// ============================================================================
// Module   : execute_mem_storebuffer_checkpoints_mc
// Brief    : Branch checkpoint table of one-hot store-buffer FIFO pointers,
//            aged by store commits, with a forwarded recovery read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_mem_storebuffer_checkpoints_mc #(
    parameter int CP_COUNT   = 4,
    parameter int CP_ADDR_W  = $clog2(CP_COUNT),
    parameter int PTR_W      = 7,
    parameter int COMMIT_MAX = 2,
    parameter int CNT_W      = $clog2(COMMIT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wea,
    input  logic [CP_ADDR_W-1:0] addra,
    input  logic [PTR_W-1:0]     dina_fifo_p,
    input  logic                 web,
    input  logic [CP_ADDR_W-1:0] addrb,
    output logic [PTR_W-1:0]     doutb_fifo_p,
    output logic                 doutb_valid,
    output logic                 doutb_err,
    input  logic [CNT_W-1:0]     wec_cnt,
    input  logic                 wed,
    input  logic [CP_ADDR_W-1:0] addrd,
    input  logic                 flush,
    output logic [CP_COUNT-1:0]  cp_valid,
    output logic                 cp_full,
    output logic                 err_any
);

    localparam logic [PTR_W-1:0] C_HEAD       = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_COMMIT_MAX = CNT_W'(COMMIT_MAX);

    // Positions below bit n are the ones a commit of n would push past the head.
    function automatic logic [PTR_W-1:0] f_low_mask(input logic [CNT_W-1:0] n);
        return (C_HEAD << n) - C_HEAD;
    endfunction

    function automatic logic f_under(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
        return |(p & f_low_mask(n));
    endfunction

    function automatic logic [PTR_W-1:0] f_shift(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
        return (p >> n) | {{(PTR_W-1){1'b0}}, f_under(p, n)};
    endfunction

    logic [PTR_W-1:0]    r_ptr [CP_COUNT];
    logic [CP_COUNT-1:0] r_valid;
    logic [CP_COUNT-1:0] r_err;

    logic [CNT_W-1:0]    w_n;
    logic [PTR_W-1:0]    w_dina_s;
    logic                w_dina_u;
    logic [PTR_W-1:0]    w_ptr_s [CP_COUNT];
    logic [CP_COUNT-1:0] w_ptr_u;
    logic [CP_COUNT-1:0] w_wr_hit;
    logic [CP_COUNT-1:0] w_rel_hit;
    logic [PTR_W-1:0]    w_rd_ptr;
    logic                w_rd_err;
    logic                w_rd_vld;

    assign w_n      = (wec_cnt > C_COMMIT_MAX) ? C_COMMIT_MAX : wec_cnt;
    assign w_dina_s = f_shift(dina_fifo_p, w_n);
    assign w_dina_u = f_under(dina_fifo_p, w_n);

    // Per-entry decode; out-of-range addresses simply match no entry.
    always_comb begin
        for (int i = 0; i < CP_COUNT; i++) begin
            w_ptr_s[i]   = f_shift(r_ptr[i], w_n);
            w_ptr_u[i]   = f_under(r_ptr[i], w_n);
            w_wr_hit[i]  = wea & (addra == CP_ADDR_W'(i));
            w_rel_hit[i] = wed & (addrd == CP_ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CP_COUNT; i++) begin
                r_ptr[i] <= C_HEAD;
            end
            r_valid <= '0;
            r_err   <= '0;
        end else begin
            for (int i = 0; i < CP_COUNT; i++) begin
                if (flush) begin
                    r_ptr[i]   <= w_ptr_s[i];
                    r_valid[i] <= 1'b0;
                    r_err[i]   <= 1'b0;
                end else if (w_wr_hit[i]) begin
                    r_ptr[i]   <= w_dina_s;
                    r_valid[i] <= 1'b1;
                    r_err[i]   <= w_dina_u;
                end else if (w_rel_hit[i]) begin
                    r_ptr[i]   <= w_ptr_s[i];
                    r_valid[i] <= 1'b0;
                end else begin
                    r_ptr[i]   <= w_ptr_s[i];
                    r_err[i]   <= r_err[i] | (r_valid[i] & w_ptr_u[i]);
                end
            end
        end
    end

    // Recovery read sees this cycle's commits and a same-cycle write.
    always_comb begin
        w_rd_ptr = C_HEAD;
        w_rd_err = 1'b0;
        w_rd_vld = 1'b0;
        for (int i = 0; i < CP_COUNT; i++) begin
            if (addrb == CP_ADDR_W'(i)) begin
                if (w_wr_hit[i] && !flush) begin
                    w_rd_ptr = w_dina_s;
                    w_rd_err = w_dina_u;
                    w_rd_vld = 1'b1;
                end else begin
                    w_rd_ptr = w_ptr_s[i];
                    w_rd_err = r_err[i] | w_ptr_u[i];
                    w_rd_vld = r_valid[i];
                end
            end
        end
    end

    assign doutb_fifo_p = w_rd_ptr;
    assign doutb_err    = w_rd_err;
    assign doutb_valid  = web & w_rd_vld & ~flush;
    assign cp_valid     = r_valid;
    assign cp_full      = &r_valid;
    assign err_any      = |(r_err & r_valid);

endmodule

`default_nettype wire

// File: tb/tb_execute_mem_storebuffer_checkpoints_mc.sv
// ============================================================================
// Module   : tb_execute_mem_storebuffer_checkpoints_mc
// Brief    : Directed scoreboard bench for the store-buffer checkpoint table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_mem_storebuffer_checkpoints_mc;

    localparam logic [5:0] M_PTR  = 6'b000001;
    localparam logic [5:0] M_VLD  = 6'b000010;
    localparam logic [5:0] M_ERR  = 6'b000100;
    localparam logic [5:0] M_CPV  = 6'b001000;
    localparam logic [5:0] M_FULL = 6'b010000;
    localparam logic [5:0] M_ERRA = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic       wea;
    logic [1:0] addra;
    logic [6:0] dina_fifo_p;
    logic       web;
    logic [1:0] addrb;
    logic [6:0] doutb_fifo_p;
    logic       doutb_valid;
    logic       doutb_err;
    logic [1:0] wec_cnt;
    logic       wed;
    logic [1:0] addrd;
    logic       flush;
    logic [3:0] cp_valid;
    logic       cp_full;
    logic       err_any;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [5:0] m;
        logic [6:0] ptr;
        logic       vld;
        logic       err;
        logic [3:0] cpv;
        logic       full;
        logic       erra;
    } exp_t;

    exp_t q[$];

    execute_mem_storebuffer_checkpoints_mc dut (
        .clk          (clk),
        .reset        (reset),
        .wea          (wea),
        .addra        (addra),
        .dina_fifo_p  (dina_fifo_p),
        .web          (web),
        .addrb        (addrb),
        .doutb_fifo_p (doutb_fifo_p),
        .doutb_valid  (doutb_valid),
        .doutb_err    (doutb_err),
        .wec_cnt      (wec_cnt),
        .wed          (wed),
        .addrd        (addrd),
        .flush        (flush),
        .cp_valid     (cp_valid),
        .cp_full      (cp_full),
        .err_any      (err_any)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [5:0] m, input logic [6:0] ptr,
                        input logic vld, input logic err, input logic [3:0] cpv,
                        input logic full, input logic erra);
        exp_t e;
        e.tag = tag; e.m = m; e.ptr = ptr; e.vld = vld; e.err = err;
        e.cpv = cpv; e.full = full; e.erra = erra;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input string f, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %b, expected %b", tag, f, act, exp);
        end
    endtask

    task automatic idle();
        wea = 0; addra = 0; dina_fifo_p = 7'b0000001; web = 0; addrb = 0;
        wec_cnt = 0; wed = 0; addrd = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are continuously presented, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.m & M_PTR)  chk(e.tag, "ptr",  doutb_fifo_p, e.ptr);
                if (e.m & M_VLD)  chk(e.tag, "vld",  7'(doutb_valid), 7'(e.vld));
                if (e.m & M_ERR)  chk(e.tag, "err",  7'(doutb_err), 7'(e.err));
                if (e.m & M_CPV)  chk(e.tag, "cpv",  7'(cp_valid), 7'(e.cpv));
                if (e.m & M_FULL) chk(e.tag, "full", 7'(cp_full), 7'(e.full));
                if (e.m & M_ERRA) chk(e.tag, "erra", 7'(err_any), 7'(e.erra));
            end
        end
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        push("reset", M_PTR|M_VLD|M_ERR|M_CPV|M_FULL|M_ERRA, 7'b0000001, 0, 0, 4'b0000, 0, 0);
        step();
        reset = 0;

        // Write addr 2 with forwarding, then stored read
        wea = 1; addra = 2; dina_fifo_p = 7'b1000000; web = 1; addrb = 2;
        push("wr2_fwd", M_PTR|M_VLD|M_ERR|M_CPV, 7'b1000000, 1, 0, 4'b0000, 0, 0);
        step(); idle();
        web = 1; addrb = 2;
        push("wr2_rd", M_PTR|M_VLD|M_ERR|M_CPV|M_FULL|M_ERRA, 7'b1000000, 1, 0, 4'b0100, 0, 0);
        step(); idle();

        // Two commits of 2 land exactly on head without error
        wea = 1; addra = 0; dina_fifo_p = 7'b0010000;
        step(); idle();
        wec_cnt = 2; web = 1; addrb = 0;
        push("age1", M_PTR|M_VLD|M_ERR|M_CPV, 7'b0000100, 1, 0, 4'b0101, 0, 0);
        step();
        push("age2", M_PTR|M_VLD|M_ERR, 7'b0000001, 1, 0, 4'b0101, 0, 0);
        step(); idle();
        web = 1; addrb = 0;
        push("age_held", M_PTR|M_ERR|M_ERRA, 7'b0000001, 1, 0, 4'b0101, 0, 0);
        step(); idle();

        // Underflow on entry 1, then cleared by rewrite
        wea = 1; addra = 1; dina_fifo_p = 7'b0000010;
        step(); idle();
        wec_cnt = 2; web = 1; addrb = 1;
        push("uf_comb", M_PTR|M_VLD|M_ERR|M_CPV|M_ERRA, 7'b0000001, 1, 1, 4'b0111, 0, 0);
        step(); idle();
        web = 1; addrb = 1;
        push("uf_reg", M_PTR|M_VLD|M_ERR|M_ERRA, 7'b0000001, 1, 1, 4'b0111, 0, 1);
        step(); idle();
        wea = 1; addra = 1; dina_fifo_p = 7'b0100000; web = 1; addrb = 1;
        push("uf_rewr", M_PTR|M_VLD|M_ERR, 7'b0100000, 1, 0, 4'b0111, 0, 0);
        step(); idle();
        web = 1; addrb = 1;
        push("uf_clr", M_PTR|M_ERR|M_ERRA, 7'b0100000, 1, 0, 4'b0111, 0, 1);
        step(); idle();

        // Same-cycle write + commit + read forwarding
        wea = 1; addra = 1; dina_fifo_p = 7'b0001000; wec_cnt = 1; web = 1; addrb = 1;
        push("fwd_commit", M_PTR|M_VLD|M_ERR, 7'b0000100, 1, 0, 4'b0111, 0, 0);
        step(); idle();
        web = 1; addrb = 1;
        push("fwd_stored", M_PTR|M_VLD|M_ERR|M_CPV, 7'b0000100, 1, 0, 4'b0111, 0, 0);
        step(); idle();

        // Fill all entries, clearing stale errors on 0 and 2
        wea = 1; addra = 3; dina_fifo_p = 7'b0000010;
        step();
        addra = 0; dina_fifo_p = 7'b0001000;
        step();
        addra = 2; dina_fifo_p = 7'b0001000;
        step(); idle();
        push("full", M_CPV|M_FULL|M_ERRA, 7'b0, 0, 0, 4'b1111, 1, 0);
        wea = 1; addra = 3; dina_fifo_p = 7'b0000100; wed = 1; addrd = 3;
        step(); idle();
        wed = 1; addrd = 3; web = 1; addrb = 3;
        push("wr_beats_rel", M_PTR|M_VLD|M_CPV|M_FULL, 7'b0000100, 1, 0, 4'b1111, 1, 0);
        step(); idle();
        web = 1; addrb = 3;
        push("release", M_VLD|M_CPV|M_FULL, 7'b0, 0, 0, 4'b0111, 0, 0);
        step(); idle();

        // Flush drops a same-cycle write
        flush = 1; wea = 1; addra = 0; dina_fifo_p = 7'b1000000; web = 1; addrb = 0;
        push("flush_comb", M_PTR|M_VLD, 7'b0001000, 0, 0, 4'b0111, 0, 0);
        step(); idle();
        web = 1; addrb = 0;
        push("flush_reg", M_PTR|M_VLD|M_CPV|M_FULL|M_ERRA, 7'b0001000, 0, 0, 4'b0000, 0, 0);
        step(); idle();

        // Asynchronous reset in the middle of a commit
        wea = 1; addra = 2; dina_fifo_p = 7'b1000000;
        step(); idle();
        wec_cnt = 1; web = 1; addrb = 2;
        push("pre_rst", M_PTR|M_VLD, 7'b0100000, 1, 0, 4'b0100, 0, 0);
        step();
        reset = 1;
        push("mid_rst", M_PTR|M_VLD|M_ERR|M_CPV|M_ERRA, 7'b0000001, 0, 1, 4'b0000, 0, 0);
        step(); idle();
        reset = 0; web = 1; addrb = 2;
        push("post_rst", M_PTR|M_VLD|M_CPV, 7'b0000001, 0, 0, 4'b0000, 0, 0);
        step(); idle();
        wea = 1; addra = 2; dina_fifo_p = 7'b0000100;
        step(); idle();
        web = 1; addrb = 2;
        push("rst_recover", M_PTR|M_VLD|M_CPV, 7'b0000100, 1, 0, 4'b0100, 0, 0);
        step(); idle();

        // Commit count above COMMIT_MAX is clamped to 2
        wec_cnt = 3; web = 1; addrb = 2;
        push("clamp", M_PTR|M_VLD|M_ERR, 7'b0000001, 1, 0, 4'b0100, 0, 0);
        step(); idle();

        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
